// File: rtl/alu_result_tx.sv
// alu_result_tx: sends {A0|sel} header then ALU result as two 8N1 bytes on one serial line
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] y_in,
  input  logic [2:0] sel_in,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;
  state_t         r_state;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic           r_byte;
  logic [7:0]     r_y;
  logic [2:0]     r_sel;
  logic           r_tx;
  logic           r_busy;
  logic           r_done;
  logic [7:0]     w_cur;
  logic           w_end;
  logic [2:0]     w_nbit;
  assign w_cur  = r_byte ? r_y : {5'b10100, r_sel};
  assign w_end  = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_nbit = r_bit + 3'd1;
  assign tx     = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;
  // tx is loaded with the next bit's value on the boundary edge so the line is purely registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= 1'b0;
      r_y     <= '0;
      r_sel   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_baud <= (r_state == IDLE || w_end) ? '0 : r_baud + BW'(1);
      case (r_state)
        IDLE: if (start) begin
          r_state <= START_BIT;
          r_byte  <= 1'b0;
          r_y     <= y_in;
          r_sel   <= sel_in;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
        end
        START_BIT: if (w_end) begin
          r_state <= DATA;
          r_bit   <= 3'd0;
          r_tx    <= w_cur[0];
        end
        DATA: if (w_end) begin
          if (r_bit == 3'd7) begin
            r_state <= STOP_BIT;
            r_tx    <= 1'b1;
          end else begin
            r_bit <= w_nbit;
            r_tx  <= w_cur[w_nbit];
          end
        end
        STOP_BIT: if (w_end) begin
          if (!r_byte) begin
            r_state <= START_BIT;
            r_byte  <= 1'b1;
            r_tx    <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_byte  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter for ALU results. It captures an 8-bit ALU result and its 3-bit operation select on a start strobe. It then sends both over a single UART-style line as two 8N1 bytes: a header byte carrying the operation code, then the result byte. It sits downstream of the ALU, returning results off-chip over one output pin instead of eight parallel pins.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit period. Legal range is ≥ 2.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- y_in  in  8  ALU result to transmit.
- sel_in  in  3  ALU operation select that produced y_in.
- start  in  1  request to transmit; sampled on each rising edge.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse marking frame completion.

## Operation
- Frame: two bytes, sent in order.
  - Byte 0 (header) = {5'b10100, sel} = 8'hA0 | sel.
  - Byte 1 = y.
- Each byte is 10 bit periods: start bit 0, then 8 data bits LSB first, then stop bit 1.
- Frame length is 20 bit periods = 20·CLKS_PER_BIT cycles.
- Capture: y_in and sel_in are latched into internal registers when start is accepted. Input changes during a frame have no effect.
- Acceptance: start is accepted only at an edge where the FSM is IDLE. start sampled while busy is ignored and not queued.
- FSM states:
  - IDLE: tx=1, busy=0. On start → START_BIT with byte index 0; latch the operands.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles → DATA with bit index 0.
  - DATA: tx = current byte[bit index], held for CLKS_PER_BIT cycles per bit. After bit 7 → STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
    - If byte index is 0: → START_BIT with byte index 1.
    - If byte index is 1: → IDLE and pulse done.
- Counters:
  - Baud counter: 0..CLKS_PER_BIT-1, reloaded on every bit boundary.
  - Bit index: 3 bits.
  - Byte index: 1 bit.
- tx, busy and done are driven directly from registers (glitch-free).
- Reset: asynchronous assertion forces tx=1, busy=0, done=0 and state IDLE, and clears all counters. A frame in progress is aborted without a done pulse. Latched operands need not be cleared.

## Timing
- Let the accepting edge be E (start=1 and IDLE sampled at E).
- After E: tx=0, busy=1. This is the first cycle of the start bit.
- Bit n of the frame (n=0..19) occupies the cycles after edges E+n·CLKS_PER_BIT through E+(n+1)·CLKS_PER_BIT-1.
- At edge E+20·CLKS_PER_BIT:
  - busy→0 and done→1 for exactly one cycle.
  - tx stays 1.
  - State is IDLE.
- Earliest next acceptance is edge E+20·CLKS_PER_BIT+1. With start held high continuously, the line idles for exactly one cycle between frames.
- start coincident with the done edge is not accepted, because the FSM was not IDLE before that edge.
- Reset values: tx=1, busy=0, done=0.
- After reset release, start is accepted on the first edge at which rst_n is high.

## Test plan
All scenarios use CLKS_PER_BIT=4, so a frame is 80 cycles.
- Reset: hold rst_n=0 with random inputs → tx=1, busy=0, done=0 throughout. After release with start=0, outputs remain unchanged for 100 cycles.
- Basic frame: sel_in=3'b010, y_in=8'h5A, one-cycle start → tx per bit period is 0, 0,1,0,0,0,1,0,1, 1, 0, 0,1,0,1,1,0,1,0, 1 (each bit 4 cycles). done pulses once, 80 cycles after acceptance, and busy falls on that same edge.
- Ignore while busy: at cycle 20 of a frame (sel=0, y=8'h00), pulse start with sel=7, y=8'hFF and change the inputs → the frame still sends 8'hA0 then 8'h00. No second frame follows.
- Reset mid-frame: assert rst_n=0 at cycle 30 → tx=1 and busy=0 immediately, asynchronously, with no done. After release, start with sel=5, y=8'h3C → a full frame sending 8'hA5, 8'h3C.
- Back-to-back: hold start=1 with sel=7, y=8'hFF →
  - Frame 1 sends 8'hA7, 8'hFF.
  - tx is high for exactly 1 idle cycle after done.
  - Frame 2 starts on the next edge.
- Capture: change y_in and sel_in every cycle during a frame → the transmitted bits match only the values sampled at the accepting edge.
